decode_pack_stage: RTL
======================

# decode_pack_stage

Decode-side producer for the instruction buffer. Takes up to `FETCH_BANDWIDTH` (4) instructions per cycle from FetchStage2. Each instruction expands into one or two decoded packets. The block compacts those packets in program order into an 8-slot registered bundle and drives the buffer's write interface (`decodeReady`, `decodedVector`, `decodedPacket0..7`). It honours the buffer's `stallFetch` backpressure and propagates it upstream.

## Interface
Parameters:
- `PKT_W`, default 96: width of one decoded packet (top level sets it to the full decoded-packet width).
- `FETCH_W`, default 4: instructions per fetch bundle.
- `SLOTS`, default 8: output slots, equal to 2*`FETCH_W`.
- `CNT_W`, default 32: statistics counter width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  misprediction flush; synchronous clear of the output stage.
- `fetchReady_i`  in  1  fetch bundle present this cycle.
- `fetchValid_i`  in  `FETCH_W`  per-instruction valid.
- `fetchSplit_i`  in  `FETCH_W`  instruction j produces two packets (A then B).
- `fetchPktA_i`  in  `FETCH_W`*`PKT_W`  first packet of instruction j, at `[j*PKT_W +: PKT_W]`.
- `fetchPktB_i`  in  `FETCH_W`*`PKT_W`  second packet of instruction j; used only when split.
- `stallFetch_i`  in  1  instruction buffer cannot accept this cycle.
- `stall_o`  out  1  upstream hold; fetch must keep its bundle stable.
- `decodeReady_o`  out  1  output bundle valid.
- `decodedVector_o`  out  `SLOTS`  per-slot valid; always contiguous from bit 0.
- `decodedPacket_o`  out  `SLOTS`*`PKT_W`  slot k at `[k*PKT_W +: PKT_W]`.
- `pktCount_o`  out  `CNT_W`  total packets accepted by the buffer.
- `stallCycles_o`  out  `CNT_W`  cycles with `stall_o`=1.

## Operation
- Compaction is combinational over the input bundle.
  - Instructions are walked in order j=0..3. Only `fetchValid_i[j]` counts; `fetchSplit_i[j]` is ignored when valid is 0.
  - Valid j emits A into the next free slot. If split, it then emits B into the slot after.
  - Slot index for instruction j = sum over i<j of (valid[i] + (valid[i]&split[i])).
  - `n` = total packets, 0..8. The next vector is `(1<<n)-1`.
- Output stage is a single register holding `decodeReady_o`, `decodedVector_o` and `decodedPacket_o`.
  - Consumed = `decodeReady_o & ~stallFetch_i`. This matches the buffer's write-enable rule.
  - Load enable = `~decodeReady_o | ~stallFetch_i`, i.e. the register is empty or being consumed.
  - On load: `decodeReady_o` <= `fetchReady_i & (n!=0)`; vector <= next vector; packets <= compacted packets. Unused slots are loaded with 0.
  - No load: all output-stage state holds.
- `stall_o` = `decodeReady_o & stallFetch_i`, combinational. Upstream must hold while it is 1. The block never drops a presented bundle except on flush.
- Counters:
  - `pktCount_o` += popcount(`decodedVector_o`) on each consumed cycle.
  - `stallCycles_o` += 1 on each cycle with `stall_o`=1.
  - Both wrap modulo 2^`CNT_W`.
  - Neither counter is cleared by flush.
- Flush:
  - Next edge: `decodeReady_o`=0 and vector=0. The input bundle in the same cycle is discarded.
  - Flush has priority over load and hold.
  - Counters still account for a consume occurring in the flush cycle.

## Timing
- Latency: input bundle to `decodeReady_o` is 1 cycle when the output stage is loadable.
- Throughput: one bundle per cycle while `stallFetch_i`=0.
- Reset (asynchronous, `reset`=0): `decodeReady_o`=0, `decodedVector_o`=0, `decodedPacket_o`=0, `pktCount_o`=0, `stallCycles_o`=0, hence `stall_o`=0. Outputs are released on the first edge after `reset` rises.
- Reset asserted mid-stall: the held bundle is lost and `stall_o` drops immediately (asynchronously).
- `stallFetch_i` with the output stage empty: `stall_o`=0 and a new bundle still loads. It is then held until `stallFetch_i` falls.
- `fetchReady_i`=1 with all valids 0: loads an empty stage (`decodeReady_o`=0) and is not counted.
- Maximum bundle (4 valid, all split): n=8, vector 0xFF, slot order A0 B0 A1 B1 A2 B2 A3 B3.

## Test plan
- Reset then idle: hold `reset`=0 for 3 cycles, release; inputs idle → all outputs 0, `stall_o`=0.
- Compaction, mixed bundle: valid=4'b1011, split=4'b0010, A/B packets = distinct tags.
  - Next cycle: vector=8'b0000_1111; slots = A0, A1, B1, A3; `decodeReady_o`=1.
  - `pktCount_o` then becomes 4.
- Backpressure: after the bundle above loads, hold `stallFetch_i`=1 for 3 cycles.
  - `stall_o`=1 for those 3 cycles; outputs stable; `stallCycles_o`=3; `pktCount_o` unchanged.
  - On release: consumed, and the next bundle loads on the same edge.
- Full split: valid=4'hF, split=4'hF, no stall → vector=8'hFF in order A0 B0 … A3 B3; `pktCount_o` +8.
- Flush during stall: stage valid with `stallFetch_i`=1, assert `flush_i` with a new valid bundle present.
  - Next cycle: `decodeReady_o`=0, vector=0, `stall_o`=0; the new bundle does not appear.
- Counter wrap: force `pktCount_o` to 2^32-2, consume a 4-packet bundle → `pktCount_o`=2.

Source files
------------

// File: rtl/decode_pack_stage.sv
// Decode-side producer for the instruction buffer: compacts up to FETCH_W
// instructions (one or two packets each) into an in-order registered slot bundle.
module decode_pack_stage #(
    parameter int unsigned PKT_W   = 96,
    parameter int unsigned FETCH_W = 4,
    parameter int unsigned SLOTS   = 8,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     fetchReady_i,
    input  logic [FETCH_W-1:0]       fetchValid_i,
    input  logic [FETCH_W-1:0]       fetchSplit_i,
    input  logic [FETCH_W*PKT_W-1:0] fetchPktA_i,
    input  logic [FETCH_W*PKT_W-1:0] fetchPktB_i,
    input  logic                     stallFetch_i,
    output logic                     stall_o,
    output logic                     decodeReady_o,
    output logic [SLOTS-1:0]         decodedVector_o,
    output logic [SLOTS*PKT_W-1:0]   decodedPacket_o,
    output logic [CNT_W-1:0]         pktCount_o,
    output logic [CNT_W-1:0]         stallCycles_o
);

    logic [SLOTS*PKT_W-1:0] nextPackets;
    logic [SLOTS-1:0]       nextVector;
    logic                   nextNonEmpty;
    logic [CNT_W-1:0]       vectorPopCount;
    logic                   consumed;
    logic                   loadEn;

    // In-order compaction: each valid instruction takes the next free slot(s).
    always_comb begin
        int unsigned slot;
        nextPackets  = '0;
        nextVector   = '0;
        nextNonEmpty = 1'b0;
        slot         = 0;
        for (int unsigned j = 0; j < FETCH_W; j++) begin
            if (fetchValid_i[j]) begin
                nextPackets[slot*PKT_W +: PKT_W] = fetchPktA_i[j*PKT_W +: PKT_W];
                slot = slot + 1;
                if (fetchSplit_i[j]) begin
                    nextPackets[slot*PKT_W +: PKT_W] = fetchPktB_i[j*PKT_W +: PKT_W];
                    slot = slot + 1;
                end
            end
        end
        for (int unsigned k = 0; k < SLOTS; k++) begin
            nextVector[k] = (k < slot);
        end
        nextNonEmpty = (slot != 0);
    end

    always_comb begin
        vectorPopCount = '0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            vectorPopCount = vectorPopCount + CNT_W'(decodedVector_o[k]);
        end
    end

    assign consumed = decodeReady_o & ~stallFetch_i;
    assign loadEn   = ~decodeReady_o | ~stallFetch_i;
    assign stall_o  = decodeReady_o & stallFetch_i;

    // Output stage plus statistics; flush clears only the stage, not the counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            decodeReady_o   <= 1'b0;
            decodedVector_o <= '0;
            decodedPacket_o <= '0;
            pktCount_o      <= '0;
            stallCycles_o   <= '0;
        end else begin
            if (consumed) begin
                pktCount_o <= pktCount_o + vectorPopCount;
            end
            if (stall_o) begin
                stallCycles_o <= stallCycles_o + CNT_W'(1);
            end
            if (flush_i) begin
                decodeReady_o   <= 1'b0;
                decodedVector_o <= '0;
            end else if (loadEn) begin
                decodeReady_o   <= fetchReady_i & nextNonEmpty;
                decodedVector_o <= nextVector;
                decodedPacket_o <= nextPackets;
            end
        end
    end

endmodule
